// File: rtl/gcd_lcm_sequencer.sv
// Multi-cycle GCD/LCM unit sitting beside the ALU in execute.
// GCD by subtractive Euclid; LCM = (a0/g)*b0 via a restoring divider
// followed by a shift-add multiplier. Holds the pipeline with stall_o.
module gcd_lcm_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GCD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   x, y, a0, b0, g;
    logic               op_q;
    logic [WIDTH-1:0]   rem, quot;
    logic [2*WIDTH-1:0] prod;
    logic [CNT_W-1:0]   cnt;

    logic               gcd_hit;
    logic [WIDTH-1:0]   g_val;
    logic               cnt_last;
    logic [WIDTH:0]     rem_sh;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt, quot_nxt;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] prod_nxt;

    assign stall_o  = ((state == S_IDLE) & start_i) | (busy_o & ~done_o);
    assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

    // Euclid termination test, in priority order; g_val is the gcd when hit.
    always_comb begin
        gcd_hit = 1'b0;
        g_val   = '0;
        if (x == '0) begin
            gcd_hit = 1'b1;
            g_val   = y;
        end else if (y == '0) begin
            gcd_hit = 1'b1;
            g_val   = x;
        end else if (x == y) begin
            gcd_hit = 1'b1;
            g_val   = x;
        end
    end

    // One restoring-divider step and one shift-add multiplier step.
    always_comb begin
        rem_sh   = {rem, quot[WIDTH-1]};
        q_bit    = (rem_sh >= {1'b0, g});
        rem_nxt  = q_bit ? WIDTH'(rem_sh - {1'b0, g}) : rem_sh[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], q_bit};
        msum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, b0} : '0);
        prod_nxt = {msum, prod[WIDTH-1:1]};
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_GCD;
            S_GCD: begin
                if (gcd_hit) begin
                    if (!op_q || g_val == '0 || a0 == '0 || b0 == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_DIV;
                end
            end
            S_DIV:  if (cnt_last) state_nxt = S_MUL;
            S_MUL:  if (cnt_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/done flags derived from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_o <= (state_nxt != S_IDLE);
            done_o <= (state_nxt == S_DONE);
        end
    end

    // Operand capture, Euclid/divide/multiply datapath and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x        <= '0;
            y        <= '0;
            a0       <= '0;
            b0       <= '0;
            g        <= '0;
            op_q     <= 1'b0;
            rem      <= '0;
            quot     <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_o <= '0;
            ovf_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        x     <= a_i;
                        y     <= b_i;
                        a0    <= a_i;
                        b0    <= b_i;
                        op_q  <= op_i;
                        ovf_o <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_GCD: begin
                    if (gcd_hit) begin
                        g    <= g_val;
                        rem  <= '0;
                        quot <= a0;
                        cnt  <= '0;
                        if (state_nxt == S_DONE)
                            result_o <= op_q ? '0 : g_val;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                S_DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last)
                        prod <= {{WIDTH{1'b0}}, quot_nxt};
                end
                S_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= cnt_last ? '0 : cnt + 1'b1;
                    if (cnt_last) begin
                        result_o <= prod_nxt[WIDTH-1:0];
                        ovf_o    <= |prod_nxt[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_lcm_sequencer.sv
// Directed bench for gcd_lcm_sequencer (WIDTH=32).
module tb_gcd_lcm_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start_i;
    logic        op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        ovf_o;

    int checks = 0;
    int errors = 0;

    gcd_lcm_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation in the current (IDLE) cycle and follow it to done.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic eo, input int lat);
        int k;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        #1;
        chk($sformatf("%s stall_on_start", tag), {63'd0, stall_o}, 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        k = 1;
        chk($sformatf("%s ovf_cleared", tag), {63'd0, ovf_o}, 64'd0);
        chk($sformatf("%s busy_after_accept", tag), {63'd0, busy_o}, 64'd1);
        while (!done_o && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("%s done", tag), {63'd0, done_o}, 64'd1);
        chk($sformatf("%s latency", tag), 64'(k), 64'(lat));
        chk($sformatf("%s result", tag), {32'd0, result_o}, {32'd0, er});
        chk($sformatf("%s ovf", tag), {63'd0, ovf_o}, {63'd0, eo});
        chk($sformatf("%s stall_in_done", tag), {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        chk($sformatf("%s done_pulse_end", tag), {63'd0, done_o}, 64'd0);
        chk($sformatf("%s busy_dropped", tag), {63'd0, busy_o}, 64'd0);
        chk($sformatf("%s result_held", tag), {32'd0, result_o}, {32'd0, er});
    endtask

    initial begin
        int ndone;
        int done_at;
        int stall_bad;
        logic [31:0] res_at_done;

        reset_n = 1'b0;
        start_i = 1'b0;
        op_i    = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, busy_o}, 64'd0);
        chk("reset done", {63'd0, done_o}, 64'd0);
        chk("reset result", {32'd0, result_o}, 64'd0);
        chk("reset ovf", {63'd0, ovf_o}, 64'd0);
        chk("reset stall", {63'd0, stall_o}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", {63'd0, busy_o}, 64'd0);

        // gcd(12,18): (12,18)->(12,6)->(6,6), N=3
        run_op("gcd12_18", 1'b0, 32'd12, 32'd18, 32'd6, 1'b0, 4);
        // lcm(4,6): N=3, 3+64+1
        run_op("lcm4_6", 1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 68);
        // zero operands
        run_op("gcd0_5", 1'b0, 32'd0, 32'd5, 32'd5, 1'b0, 2);
        run_op("gcd7_0", 1'b0, 32'd7, 32'd0, 32'd7, 1'b0, 2);
        run_op("gcd0_0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 2);
        run_op("lcm0_9", 1'b1, 32'd0, 32'd9, 32'd0, 1'b0, 2);
        run_op("lcm7_0", 1'b1, 32'd7, 32'd0, 32'd0, 1'b0, 2);
        // lcm(5,7): (5,7)->(5,2)->(3,2)->(1,2)->(1,1), N=5
        run_op("lcm5_7", 1'b1, 32'd5, 32'd7, 32'd35, 1'b0, 70);
        // lcm overflow: g=0x40000000, q=3, p=3*0x80000000=0x1_8000_0000
        run_op("lcm_ovf", 1'b1, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 68);
        // next accept must clear ovf; full-scale equal gcd
        run_op("gcd_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2);

        // start pulses while busy (during GCD and DIV) are ignored
        start_i = 1'b1; op_i = 1'b1; a_i = 32'd4; b_i = 32'd6;
        @(posedge clk); #1;
        ndone = 0; done_at = 0; stall_bad = 0; res_at_done = '0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 2 || k == 10) begin
                start_i = 1'b1; op_i = 1'b0; a_i = 32'd9; b_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (done_o) begin
                ndone++;
                done_at = k;
                res_at_done = result_o;
            end else if (k < 68 && !stall_o) begin
                stall_bad++;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        chk("ignore ndone", 64'(ndone), 64'd1);
        chk("ignore latency", 64'(done_at), 64'd68);
        chk("ignore result", {32'd0, res_at_done}, 64'd12);
        chk("ignore stall_gaps", 64'(stall_bad), 64'd0);
        chk("ignore idle_after", {63'd0, busy_o}, 64'd0);

        // reset during DIV aborts with no done
        start_i = 1'b1; op_i = 1'b1; a_i = 32'd4; b_i = 32'd6;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort busy", {63'd0, busy_o}, 64'd0);
        chk("abort done", {63'd0, done_o}, 64'd0);
        chk("abort result", {32'd0, result_o}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("abort no_done", 64'(ndone), 64'd0);
        chk("abort idle", {63'd0, busy_o}, 64'd0);
        // gcd(9,6): (9,6)->(3,6)->(3,3), N=3
        run_op("gcd9_6", 1'b0, 32'd9, 32'd6, 32'd3, 1'b0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
